// File: rtl/vga_sync_decoder.sv
// ============================================================================
// vga_sync_decoder
// ----------------------------------------------------------------------------
// Receiver end of the VGA sync interface. It watches the H/V sync pulses from
// the sync generator and recovers the column/row position, an active-video
// flag and a frame-start pulse. These are needed by downstream pixel
// pipelines that only get syncs alongside their data.
//
// The recovered counters free-run and are re-anchored on every sync edge. A
// small FSM watches the edge spacing. It declares lock only once both H and V
// edges land where the configured mode says they should. It pulses h_err or
// v_err when an edge is early, late or missing.
//
// The generator runs on the same clock. The inputs therefore pass through a
// single register used for edge detection, with no synchronizer.
//
// Ports:
//   CLK          in   1      pixel clock
//   RST          in   1      synchronous reset, active high
//   H_sync_in    in   1      horizontal sync from the generator
//   V_sync_in    in   1      vertical sync from the generator
//   col_count    out  COL_W  recovered column
//   row_count    out  ROW_W  recovered row
//   active_video out  1      visible pixel while locked
//   frame_start  out  1      one-cycle pulse at (0,0) while locked
//   locked       out  1      FSM is in LOCKED (registered)
//   h_err        out  1      one-cycle pulse on a misplaced/missing H edge
//   v_err        out  1      one-cycle pulse on a misplaced/missing V edge
// ============================================================================
module vga_sync_decoder #(
    parameter int TOTAL_COLS      = 800,
    parameter int TOTAL_ROWS      = 525,
    parameter int ACTIVE_COLS     = 640,
    parameter int ACTIVE_ROWS     = 480,
    parameter int H_FRONT_PORCH   = 16,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_EDGE_COL      = 0,
    parameter int LOCK_LINES      = 4,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int COL_W           = 10,
    parameter int ROW_W           = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             H_sync_in,
    input  logic             V_sync_in,
    output logic [COL_W-1:0] col_count,
    output logic [ROW_W-1:0] row_count,
    output logic             active_video,
    output logic             frame_start,
    output logic             locked,
    output logic             h_err,
    output logic             v_err
);

    // Wide enough to hold LOCK_LINES itself; the line counter saturates there.
    localparam int LINE_W = $clog2(LOCK_LINES + 2);

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(TOTAL_COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(TOTAL_ROWS - 1);
    localparam logic [COL_W-1:0]  H_START    = COL_W'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [ROW_W-1:0]  V_START    = ROW_W'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [COL_W-1:0]  V_COL      = COL_W'(V_EDGE_COL);
    localparam logic [COL_W-1:0]  ACT_COLS   = COL_W'(ACTIVE_COLS);
    localparam logic [ROW_W-1:0]  ACT_ROWS   = ROW_W'(ACTIVE_ROWS);
    localparam logic [LINE_W-1:0] LOCK_COUNT = LINE_W'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH,
        H_TRACK,
        V_TRACK,
        LOCKED
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [LINE_W-1:0] line_cnt;
    logic [LINE_W-1:0] line_cnt_nx;

    logic              h_act;
    logic              v_act;
    logic              r_h;
    logic              r_v;
    logic              h_edge;
    logic              v_edge;

    logic              col_wrap;
    logic [COL_W-1:0]  col_nx;
    logic [ROW_W-1:0]  row_nx;
    logic [COL_W-1:0]  col_d;
    logic [ROW_W-1:0]  row_d;

    logic              h_exp;
    logic              v_exp;
    logic              h_mis;
    logic              v_mis;

    logic              h_err_nx;
    logic              v_err_nx;
    logic              locked_nx;
    logic              active_nx;
    logic              frame_nx;

    // Normalize the sync polarity so everything below treats "1" as asserted.
    // An edge is a deassert-to-assert transition. It is taken combinationally
    // from the live input against the previous sample.
    always_comb begin
        h_act  = (SYNC_ACTIVE_LOW != 0) ? ~H_sync_in : H_sync_in;
        v_act  = (SYNC_ACTIVE_LOW != 0) ? ~V_sync_in : V_sync_in;
        h_edge = h_act & ~r_h;
        v_edge = v_act & ~r_v;
    end

    // Free-running position and the value the counters will take this edge.
    // A sync edge reloads its counter to the point where the generator
    // asserts that sync. This happens in every state, so that the counters
    // converge even before lock.
    always_comb begin
        col_wrap = (col_count == COL_LAST);
        col_nx   = col_wrap ? '0 : col_count + 1'b1;
        if (col_wrap) begin
            row_nx = (row_count == ROW_LAST) ? '0 : row_count + 1'b1;
        end else begin
            row_nx = row_count;
        end
        col_d = h_edge ? H_START : col_nx;
        row_d = v_edge ? V_START : row_nx;
    end

    // Where an edge should land if the free-running position is right. An
    // edge without an expectation (early/late) and an expectation without an
    // edge (missing) both count as a mismatch.
    always_comb begin
        h_exp = (col_nx == H_START);
        v_exp = (col_nx == V_COL) && (row_nx == V_START);
        h_mis = h_edge ^ h_exp;
        v_mis = v_edge ^ v_exp;
    end

    // FSM state and line counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= SEARCH;
            line_cnt <= '0;
        end else begin
            state    <= state_nx;
            line_cnt <= line_cnt_nx;
        end
    end

    // Next-state logic. H problems always win over V problems, because a bad
    // column makes the V expectation meaningless. A V failure drops back to
    // H_TRACK with the line count already satisfied. The next V edge is then
    // accepted immediately as the new anchor.
    always_comb begin
        state_nx    = state;
        line_cnt_nx = line_cnt;
        case (state)
            SEARCH: begin
                if (h_edge) begin
                    state_nx    = H_TRACK;
                    line_cnt_nx = '0;
                end
            end
            H_TRACK: begin
                if (h_mis) begin
                    state_nx = SEARCH;
                end else begin
                    if (h_edge && (line_cnt < LOCK_COUNT)) begin
                        line_cnt_nx = line_cnt + 1'b1;
                    end
                    if ((line_cnt >= LOCK_COUNT) && v_edge) begin
                        state_nx = V_TRACK;
                    end
                end
            end
            V_TRACK: begin
                if (h_mis) begin
                    state_nx = SEARCH;
                end else if (v_edge && v_exp) begin
                    state_nx = LOCKED;
                end else if (v_mis) begin
                    state_nx    = H_TRACK;
                    line_cnt_nx = LOCK_COUNT;
                end
            end
            LOCKED: begin
                if (h_mis) begin
                    state_nx = SEARCH;
                end else if (v_mis) begin
                    state_nx    = H_TRACK;
                    line_cnt_nx = LOCK_COUNT;
                end
            end
            default: begin
                state_nx    = SEARCH;
                line_cnt_nx = '0;
            end
        endcase
    end

    // Output decode. Each flag is computed against the counter values being
    // loaded on this edge, so after registration it lines up with the
    // counters it describes. Gating uses the current state. This keeps
    // active_video and frame_start consistent with the registered locked
    // output, which lags the state by one cycle.
    always_comb begin
        h_err_nx  = (state != SEARCH) && h_mis;
        v_err_nx  = ((state == V_TRACK) || (state == LOCKED)) && !h_mis && v_mis;
        locked_nx = (state == LOCKED);
        active_nx = locked_nx && (col_d < ACT_COLS) && (row_d < ACT_ROWS);
        frame_nx  = locked_nx && (col_d == '0) && (row_d == '0);
    end

    // Counters, edge-detect history and registered outputs. The history
    // resets to "asserted". A sync that is already held across reset release
    // is therefore ignored until it deasserts and asserts again.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_h          <= 1'b1;
            r_v          <= 1'b1;
            col_count    <= '0;
            row_count    <= '0;
            active_video <= 1'b0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            h_err        <= 1'b0;
            v_err        <= 1'b0;
        end else begin
            r_h          <= h_act;
            r_v          <= v_act;
            col_count    <= col_d;
            row_count    <= row_d;
            active_video <= active_nx;
            frame_start  <= frame_nx;
            locked       <= locked_nx;
            h_err        <= h_err_nx;
            v_err        <= v_err_nx;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ============================================================================
// tb_vga_sync_decoder
// ----------------------------------------------------------------------------
// The bench uses a reduced video mode so that ten frames run in a few thousand
// cycles:
//   20 cols x 12 rows, 10x6 visible, H sync at cols 12..14, and V sync for
//   rows 8..9.
// Instance A asserts V at column 0. Instance B asserts V at column 12, so B's
// H and V edges coincide.
//
// A small generator model drives both decoders. It can also apply these
// disturbances:
//   - frame 3: the generator stalls 3 clocks before the row 2 H edge, so that
//     edge lands 3 cycles late.
//   - frame 5: A's V sync is suppressed.
//   - frame 8: a one-cycle reset is applied at (13,1), while H is asserted.
//
// Expected outputs are written by hand for chosen generator positions. They
// are queued as each position is driven. A monitor pops them on the negedge
// after the matching posedge.
// ============================================================================
module tb_vga_sync_decoder;

    localparam int COL_W = 5;
    localparam int ROW_W = 4;

    logic             clk;
    logic             rst;
    logic             h_sync;
    logic             v_sync_a;
    logic             v_sync_b;

    logic [COL_W-1:0] a_col;
    logic [ROW_W-1:0] a_row;
    logic             a_av;
    logic             a_fs;
    logic             a_lk;
    logic             a_he;
    logic             a_ve;

    logic [COL_W-1:0] b_col;
    logic [ROW_W-1:0] b_row;
    logic             b_av;
    logic             b_fs;
    logic             b_lk;
    logic             b_he;
    logic             b_ve;

    typedef struct {
        int inst; int f; int r; int c; int s;
        int col; int row; bit av; bit fs; bit lk; bit he; bit ve;
    } chk_t;

    typedef struct {
        int cyc; int inst;
        int col; int row; bit av; bit fs; bit lk; bit he; bit ve;
    } exp_t;

    chk_t chk_list[$];
    exp_t exp_q[$];
    exp_t mon_e;

    int cyc;
    int tests;
    int fails;
    int a_he_cnt, a_ve_cnt, b_he_cnt, b_ve_cnt;
    int a_fs_cnt, b_fs_cnt, a_av_cnt, b_av_cnt;

    vga_sync_decoder #(
        .TOTAL_COLS(20), .TOTAL_ROWS(12), .ACTIVE_COLS(10), .ACTIVE_ROWS(6),
        .H_FRONT_PORCH(2), .V_FRONT_PORCH(2), .V_EDGE_COL(0), .LOCK_LINES(4),
        .SYNC_ACTIVE_LOW(1), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut_a (
        .CLK(clk), .RST(rst), .H_sync_in(h_sync), .V_sync_in(v_sync_a),
        .col_count(a_col), .row_count(a_row), .active_video(a_av),
        .frame_start(a_fs), .locked(a_lk), .h_err(a_he), .v_err(a_ve)
    );

    vga_sync_decoder #(
        .TOTAL_COLS(20), .TOTAL_ROWS(12), .ACTIVE_COLS(10), .ACTIVE_ROWS(6),
        .H_FRONT_PORCH(2), .V_FRONT_PORCH(2), .V_EDGE_COL(12), .LOCK_LINES(4),
        .SYNC_ACTIVE_LOW(1), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut_b (
        .CLK(clk), .RST(rst), .H_sync_in(h_sync), .V_sync_in(v_sync_b),
        .col_count(b_col), .row_count(b_row), .active_video(b_av),
        .frame_start(b_fs), .locked(b_lk), .h_err(b_he), .v_err(b_ve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter; expectations are tagged with the posedge they follow.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic addCheck(input int inst, input int f, input int r, input int c,
                            input int s, input int col, input int row, input bit av,
                            input bit fs, input bit lk, input bit he, input bit ve);
        chk_t k;
        k = '{inst, f, r, c, s, col, row, av, fs, lk, he, ve};
        chk_list.push_back(k);
    endtask

    // Queue every hand-written expectation for this position. The target is
    // the posedge about to sample the position.
    task automatic queueChecks(input int f, input int r, input int c, input int s);
        exp_t e;
        foreach (chk_list[i]) begin
            if (chk_list[i].f == f && chk_list[i].r == r &&
                chk_list[i].c == c && chk_list[i].s == s) begin
                e = '{cyc + 1, chk_list[i].inst, chk_list[i].col, chk_list[i].row,
                      chk_list[i].av, chk_list[i].fs, chk_list[i].lk,
                      chk_list[i].he, chk_list[i].ve};
                exp_q.push_back(e);
            end
        end
    endtask

    // Drive one clock of generator output (sync levels given as "asserted").
    task automatic applyStimulus(input bit r, input bit ha, input bit va, input bit vb);
        rst      = r;
        h_sync   = ~ha;
        v_sync_a = ~va;
        v_sync_b = ~vb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        int col, row;
        bit av, fs, lk, he, ve;
        if (e.inst == 0) begin
            col = int'(a_col); row = int'(a_row);
            av = a_av; fs = a_fs; lk = a_lk; he = a_he; ve = a_ve;
        end else begin
            col = int'(b_col); row = int'(b_row);
            av = b_av; fs = b_fs; lk = b_lk; he = b_he; ve = b_ve;
        end
        tests++;
        if (e.cyc != cyc || col != e.col || row != e.row || av != e.av ||
            fs != e.fs || lk != e.lk || he != e.he || ve != e.ve) begin
            fails++;
            $display("[TB] FAIL pos inst%0d cyc%0d(at %0d): got col=%0d row=%0d av=%0b fs=%0b lk=%0b he=%0b ve=%0b, want col=%0d row=%0d av=%0b fs=%0b lk=%0b he=%0b ve=%0b",
                     e.inst, e.cyc, cyc, col, row, av, fs, lk, he, ve,
                     e.col, e.row, e.av, e.fs, e.lk, e.he, e.ve);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitor: pop every expectation due at this posedge. It also tallies
    // pulse and active cycles, which catches stray or stretched outputs
    // between checkpoints.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checkOutput(mon_e);
        end
        if (a_he === 1'b1) a_he_cnt++;
        if (a_ve === 1'b1) a_ve_cnt++;
        if (b_he === 1'b1) b_he_cnt++;
        if (b_ve === 1'b1) b_ve_cnt++;
        if (a_fs === 1'b1) a_fs_cnt++;
        if (b_fs === 1'b1) b_fs_cnt++;
        if (a_av === 1'b1) a_av_cnt++;
        if (b_av === 1'b1) b_av_cnt++;
    end

    task automatic buildChecks;
        //        inst f  r  c  s  col row av fs lk he ve
        // First H edge reloads the column.
        addCheck(0, 0, 0, 12, 0, 12, 0, 0, 0, 0, 0, 0);
        // First V edge enters V_TRACK; the second locks.
        addCheck(0, 0, 8,  0, 0,  0, 8, 0, 0, 0, 0, 0);
        addCheck(0, 1, 8,  0, 0,  0, 8, 0, 0, 0, 0, 0);
        addCheck(0, 1, 8,  1, 0,  1, 8, 0, 0, 1, 0, 0);
        // Locked frame: frame start and the active-window boundaries.
        addCheck(0, 2, 0,  0, 0,  0, 0, 1, 1, 1, 0, 0);
        addCheck(0, 2, 5,  9, 0,  9, 5, 1, 0, 1, 0, 0);
        addCheck(0, 2, 5, 10, 0, 10, 5, 0, 0, 1, 0, 0);
        addCheck(0, 2, 6,  0, 0,  0, 6, 0, 0, 1, 0, 0);
        // Late H edge: a missing-edge error, locked drops, then a re-anchor.
        addCheck(0, 3, 2, 12, 1, 12, 2, 0, 0, 1, 1, 0);
        addCheck(0, 3, 2, 12, 2, 13, 2, 0, 0, 0, 0, 0);
        addCheck(0, 3, 2, 12, 0, 12, 2, 0, 0, 0, 0, 0);
        addCheck(0, 3, 8,  1, 0,  1, 8, 0, 0, 0, 0, 0);
        addCheck(0, 4, 8,  1, 0,  1, 8, 0, 0, 1, 0, 0);
        // Suppressed V: v_err at (0,8), relock over the next two frames.
        addCheck(0, 5, 8,  0, 0,  0, 8, 0, 0, 1, 0, 1);
        addCheck(0, 5, 8,  1, 0,  1, 8, 0, 0, 0, 0, 0);
        addCheck(0, 6, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0);
        addCheck(0, 6, 8,  1, 0,  1, 8, 0, 0, 0, 0, 0);
        addCheck(0, 7, 8,  1, 0,  1, 8, 0, 0, 1, 0, 0);
        // Reset with H held asserted; no edge until H re-asserts.
        addCheck(0, 8, 1, 13, 0,  0, 0, 0, 0, 0, 0, 0);
        addCheck(0, 8, 1, 14, 0,  1, 0, 0, 0, 0, 0, 0);
        addCheck(0, 8, 2, 12, 0, 12, 0, 0, 0, 0, 0, 0);
        addCheck(0, 8, 8,  0, 0,  0, 8, 0, 0, 0, 0, 0);
        addCheck(0, 9, 8,  1, 0,  1, 8, 0, 0, 1, 0, 0);
        // Instance B: coincident H/V edges.
        addCheck(1, 0, 8, 12, 0, 12, 8, 0, 0, 0, 0, 0);
        addCheck(1, 1, 8, 13, 0, 13, 8, 0, 0, 1, 0, 0);
        addCheck(1, 2, 0,  0, 0,  0, 0, 1, 1, 1, 0, 0);
        addCheck(1, 3, 2, 12, 1, 12, 2, 0, 0, 1, 1, 0);
        addCheck(1, 5, 8, 13, 0, 13, 8, 0, 0, 1, 0, 0);
        addCheck(1, 8, 8, 12, 0, 12, 8, 0, 0, 0, 0, 0);
        addCheck(1, 9, 8, 13, 0, 13, 8, 0, 0, 1, 0, 0);
    endtask

    initial begin
        exp_t e;
        bit   ha, va, vb, r;
        int   pos;
        cyc = 0; tests = 0; fails = 0;
        a_he_cnt = 0; a_ve_cnt = 0; b_he_cnt = 0; b_ve_cnt = 0;
        a_fs_cnt = 0; b_fs_cnt = 0; a_av_cnt = 0; b_av_cnt = 0;
        rst = 1'b1; h_sync = 1'b1; v_sync_a = 1'b1; v_sync_b = 1'b1;
        buildChecks();
        @(posedge clk);
        #1;
        // Reset state on both instances.
        e = '{cyc + 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_q.push_back(e);
        e.inst = 1;
        exp_q.push_back(e);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 10; f++) begin
            for (int row = 0; row < 12; row++) begin
                for (int col = 0; col < 20; col++) begin
                    if (f == 3 && row == 2 && col == 12) begin
                        for (int s = 1; s <= 3; s++) begin
                            queueChecks(f, row, col, s);
                            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
                        end
                    end
                    pos = row * 20 + col;
                    r   = (f == 8 && row == 1 && col == 13);
                    ha  = (col >= 12 && col < 15);
                    va  = (pos >= 160 && pos < 200) && (f != 5);
                    vb  = (pos >= 172 && pos < 212);
                    queueChecks(f, row, col, 0);
                    applyStimulus(r, ha, va, vb);
                end
            end
        end

        @(negedge clk);
        #1;
        checkCount("a_h_err_pulses", a_he_cnt, 1);
        checkCount("a_v_err_pulses", a_ve_cnt, 1);
        checkCount("b_h_err_pulses", b_he_cnt, 1);
        checkCount("b_v_err_pulses", b_ve_cnt, 0);
        checkCount("a_frame_starts", a_fs_cnt, 4);
        checkCount("b_frame_starts", b_fs_cnt, 6);
        checkCount("a_active_cycles", a_av_cnt, 170);
        checkCount("b_active_cycles", b_av_cnt, 290);
        checkCount("unconsumed_expectations", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
